// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder: MMIO register
// offsets, the default MMIO base and a byte-enable merge for register writes.
package data_sram_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1FAF_0000;

  localparam logic [15:0] LED_OFF     = 16'h0000;
  localparam logic [15:0] SWITCH_OFF  = 16'h0004;
  localparam logic [15:0] COUNT_OFF   = 16'h0008;
  localparam logic [15:0] COMPARE_OFF = 16'h000C;
  localparam logic [15:0] STATUS_OFF  = 16'h0010;

  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/data_sram_responder_bram_be.sv
// bram_be: single-port, read-first, byte-enabled RAM with a registered read
// port; array contents are not reset, only the output register is.
module bram_be #(
  parameter  int DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = en ? mem[addr] : rdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// CPU data-port responder: byte-enabled RAM plus LED/switch/timer MMIO block.
// Define TIMER_INT_EN to enable COMPARE, STATUS and the timer interrupt.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [5:0]  int_o,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic        is_mmio, mmio_wr, ram_en, unused_addr_bits;
  logic [15:0] off;
  logic [31:0] ram_rdata, compare_rd;
  logic        pending_rd;

  logic        mmio_sel_q, mmio_sel_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic [15:0] led_q, led_d;
  logic [7:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [31:0] count_q, count_d;

  assign is_mmio          = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign off              = {data_sram_addr[15:2], 2'b00};
  assign ram_en           = data_sram_en & ~is_mmio;
  assign mmio_wr          = data_sram_en & is_mmio & (|data_sram_wen);
  assign unused_addr_bits = ^data_sram_addr[1:0];

  bram_be #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .en     (ram_en),
    .wen    (data_sram_wen),
    .addr   (data_sram_addr[AW+1:2]),
    .wdata  (data_sram_wdata),
    .rdata  (ram_rdata)
  );

  // MMIO reads are read-first, like the RAM: they capture pre-edge register values.
  always_comb begin
    mmio_sel_d   = mmio_sel_q;
    mmio_rdata_d = mmio_rdata_q;
    led_d        = led_q;
    sw_meta_d    = switch;
    sw_sync_d    = sw_meta_q;
    count_d      = count_q + 32'd1;
    if (data_sram_en) begin
      mmio_sel_d = is_mmio;
      if (is_mmio) begin
        case (off)
          LED_OFF:     mmio_rdata_d = {16'h0000, led_q};
          SWITCH_OFF:  mmio_rdata_d = {24'h000000, sw_sync_q};
          COUNT_OFF:   mmio_rdata_d = count_q;
          COMPARE_OFF: mmio_rdata_d = compare_rd;
          STATUS_OFF:  mmio_rdata_d = {31'h0, pending_rd};
          default:     mmio_rdata_d = '0;
        endcase
      end
    end
    if (mmio_wr && off == LED_OFF) begin
      if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
      if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
    end
    if (mmio_wr && off == COUNT_OFF) count_d = merge_be(count_q, data_sram_wdata, data_sram_wen);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mmio_sel_q   <= 1'b0;
      mmio_rdata_q <= '0;
      led_q        <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      count_q      <= '0;
    end else begin
      mmio_sel_q   <= mmio_sel_d;
      mmio_rdata_q <= mmio_rdata_d;
      led_q        <= led_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      count_q      <= count_d;
    end
  end

`ifdef TIMER_INT_EN
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d, match, w1c;

  // A compare match in the same cycle as a W1C clear keeps pending set.
  always_comb begin
    match     = (count_q == compare_q) && (compare_q != '0);
    w1c       = mmio_wr && (off == STATUS_OFF) && data_sram_wen[0] && data_sram_wdata[0];
    compare_d = compare_q;
    if (mmio_wr && off == COMPARE_OFF) compare_d = merge_be(compare_q, data_sram_wdata, data_sram_wen);
    pending_d = match | (pending_q & ~w1c);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare_q <= '0;
      pending_q <= 1'b0;
    end else begin
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign compare_rd = compare_q;
  assign pending_rd = pending_q;
`else
  assign compare_rd = '0;
  assign pending_rd = 1'b0;
`endif

  assign int_o           = {pending_rd, 5'b00000};
  assign led             = led_q;
  assign data_sram_rdata = mmio_sel_q ? mmio_rdata_q : ram_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed steps followed by
// randomized traffic, all checked against a behavioural model.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [5:0]  int_o;
  logic [15:0] led;
  logic [7:0]  switch = 8'h00;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_responder #(.DEPTH_WORDS(4096), .MMIO_BASE(32'h1FAF_0000)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .int_o           (int_o),
    .led             (led),
    .switch          (switch)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  // Behavioural model: RAM as a sparse word map, COUNT as "last written value
  // plus edges elapsed since", switch as the value seen two edges ago.
  logic [31:0] ram_m [int];
  logic [15:0] led_m;
  logic [31:0] cnt_base;
  int          cnt_cyc;
  logic [31:0] cmp_m;
  logic        pend_m;
  logic [7:0]  sw_e1, sw_e2;
  logic [31:0] rd_m;
  bit          rd_known;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] count_now();
    return cnt_base + 32'(cyc - cnt_cyc);
  endfunction

  task automatic modelReset();
    led_m    = 16'h0;
    cnt_base = 32'h0;
    cnt_cyc  = cyc;
    cmp_m    = 32'h0;
    pend_m   = 1'b0;
    sw_e1    = 8'h0;
    sw_e2    = 8'h0;
    rd_m     = 32'h0;
    rd_known = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request for one clock edge, advances the model, checks outputs.
  task automatic applyStimulus(input logic en, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] c, tmp;
    logic [15:0] off;
    int          idx;
    bit          mm, match, w1c;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    c     = count_now();
    mm    = (addr[31:16] == 16'h1FAF);
    off   = {addr[15:2], 2'b00};
    idx   = int'(addr[13:2]);
    match = 1'b0;
    w1c   = 1'b0;
`ifdef TIMER_INT_EN
    match = (c == cmp_m) && (cmp_m != 32'h0);
`endif
    if (en) begin
      if (mm) begin
        rd_known = 1'b1;
        case (off)
          16'h0000: rd_m = {16'h0, led_m};
          16'h0004: rd_m = {24'h0, sw_e2};
          16'h0008: rd_m = c;
`ifdef TIMER_INT_EN
          16'h000C: rd_m = cmp_m;
          16'h0010: rd_m = {31'h0, pend_m};
`endif
          default:  rd_m = 32'h0;
        endcase
      end else if (ram_m.exists(idx)) begin
        rd_m     = ram_m[idx];
        rd_known = 1'b1;
      end else begin
        rd_known = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    sw_e2 = sw_e1;
    sw_e1 = switch;
    if (en && wen != 4'h0) begin
      if (mm) begin
        case (off)
          16'h0000: begin
            tmp   = lane_merge({16'h0, led_m}, wdata, wen);
            led_m = tmp[15:0];
          end
          16'h0008: begin
            cnt_base = lane_merge(c, wdata, wen);
            cnt_cyc  = cyc;
          end
`ifdef TIMER_INT_EN
          16'h000C: cmp_m = lane_merge(cmp_m, wdata, wen);
          16'h0010: w1c = wen[0] & wdata[0];
`endif
          default: ;
        endcase
      end else if (ram_m.exists(idx)) begin
        ram_m[idx] = lane_merge(ram_m[idx], wdata, wen);
      end else if (wen == 4'hF) begin
        ram_m[idx] = wdata;
      end
    end
    pend_m = match | (pend_m & ~w1c);
    if (rd_known) checkOutput("rdata", data_sram_rdata, rd_m);
    checkOutput("int_o", {26'h0, int_o}, {26'h0, pend_m, 5'h00});
    checkOutput("led", {16'h0, led}, {16'h0, led_m});
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  localparam logic [31:0] LED_A  = 32'h1FAF_0000;
  localparam logic [31:0] SW_A   = 32'h1FAF_0004;
  localparam logic [31:0] CNT_A  = 32'h1FAF_0008;
  localparam logic [31:0] CMP_A  = 32'h1FAF_000C;
  localparam logic [31:0] STAT_A = 32'h1FAF_0010;

  logic [15:0] offs [7];

  initial begin
    logic [31:0] r, a, hi;
    logic [15:0] o;
    logic [11:0] widx;
    offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0100};
    $display("[TB] starting data_sram_responder bench");

    #1 resetn = 1'b0;
    #1;
    checkOutput("reset_rdata", data_sram_rdata, 32'h0);
    checkOutput("reset_int", {26'h0, int_o}, 32'h0);
    checkOutput("reset_led", {16'h0, led}, 32'h0);
    @(posedge clk);
    #2 resetn = 1'b1;
    modelReset();

    applyStimulus(1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 4'b0010, 32'h0000_0040, 32'h0000_5500);
    applyStimulus(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    checkOutput("ram_byte_en", data_sram_rdata, 32'hDEAD_55EF);

    applyStimulus(1'b1, 4'hF, 32'h0000_0080, 32'h1111_1111);
    applyStimulus(1'b1, 4'hF, 32'h0000_0080, 32'h1234_5678);
    checkOutput("ram_read_first", data_sram_rdata, 32'h1111_1111);
    applyStimulus(1'b1, 4'h0, 32'h0000_0080, 32'h0);
    checkOutput("ram_after_write", data_sram_rdata, 32'h1234_5678);

    applyStimulus(1'b1, 4'hF, LED_A, 32'hFFFF_A5A5);
    checkOutput("led_write", {16'h0, led}, 32'h0000_A5A5);
    applyStimulus(1'b1, 4'h0, LED_A, 32'h0);
    checkOutput("led_read", data_sram_rdata, 32'h0000_A5A5);

    switch = 8'h3C;
    idle();
    idle();
    applyStimulus(1'b1, 4'h0, SW_A, 32'h0);
    checkOutput("switch_sync", data_sram_rdata, 32'h0000_003C);

`ifdef TIMER_INT_EN
    applyStimulus(1'b1, 4'hF, CMP_A, 32'd20);
    applyStimulus(1'b1, 4'hF, CNT_A, 32'd10);
    repeat (10) idle();
    checkOutput("int_before_match", {26'h0, int_o}, 32'h0);
    idle();
    checkOutput("int_at_match", {26'h0, int_o}, 32'h20);
    applyStimulus(1'b1, 4'hF, CNT_A, 32'd100);
    applyStimulus(1'b1, 4'hF, CMP_A, 32'd102);
    idle();
    applyStimulus(1'b1, 4'hF, STAT_A, 32'h1);
    checkOutput("w1c_vs_match", {26'h0, int_o}, 32'h20);
    applyStimulus(1'b1, 4'hF, STAT_A, 32'h1);
    checkOutput("w1c_clear", {26'h0, int_o}, 32'h0);
`else
    applyStimulus(1'b1, 4'hF, CMP_A, 32'd5);
    applyStimulus(1'b1, 4'h0, CMP_A, 32'h0);
    checkOutput("compare_disabled", data_sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'hF, CNT_A, 32'd3);
    repeat (4) idle();
    checkOutput("int_disabled", {26'h0, int_o}, 32'h0);
`endif

    applyStimulus(1'b1, 4'hF, CNT_A, 32'hFFFF_FFFE);
    idle();
    applyStimulus(1'b1, 4'h0, CNT_A, 32'h0);
    checkOutput("count_pre_wrap", data_sram_rdata, 32'hFFFF_FFFF);
    idle();
    applyStimulus(1'b1, 4'h0, CNT_A, 32'h0);
    checkOutput("count_wrap", data_sram_rdata, 32'h0000_0001);

    // Reset while a request is being driven.
    applyStimulus(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    data_sram_wen   = 4'hF;
    data_sram_addr  = LED_A;
    data_sram_wdata = 32'h0000_1234;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_rdata", data_sram_rdata, 32'h0);
    checkOutput("midreset_int", {26'h0, int_o}, 32'h0);
    checkOutput("midreset_led", {16'h0, led}, 32'h0);
    data_sram_en = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b1;
    modelReset();
    applyStimulus(1'b1, 4'h0, LED_A, 32'h0);
    checkOutput("post_reset_led_read", data_sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    checkOutput("ram_survives_reset", data_sram_rdata, 32'hDEAD_55EF);

    for (int i = 32; i < 48; i++) applyStimulus(1'b1, 4'hF, 32'(i * 4), $urandom);

    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if (r[20:17] == 4'h0) switch = 8'($urandom_range(0, 255));
      if (r[9:8] == 2'b00) begin
        o = offs[$urandom_range(0, 6)];
        a = {16'h1FAF, o[15:2], r[12:11]};
      end else begin
        widx = 12'(32 + $urandom_range(0, 15));
        hi   = $urandom;
        if (hi[31:16] == 16'h1FAF) hi[16] = ~hi[16];
        a = {hi[31:14], widx, r[12:11]};
      end
      applyStimulus(r[1:0] != 2'b00, r[2] ? 4'h0 : r[7:4], a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
